// File: rtl/spi_master_write.sv
// rtl/spi_master_write.sv - SPI initiator for {R/W, adr[6:0]} + Nbit data write frames
// Optional read capture on miso is built only when SPI_MST_READ_EN is defined.
module spi_master_write #(
  parameter int Nbit  = 32,
  parameter int Dlitl = 5,
  parameter int Tcs   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_adr,
  input  logic [Nbit-1:0] req_data,
  input  logic            req_rd,
  output logic            sclk,
  output logic            mosi,
  output logic            cs,
  input  logic            miso,
  output logic            busy,
  output logic            done,
  output logic [Nbit-1:0] rd_data,
  output logic            rd_valid
);
  localparam int SW   = Nbit + 8;
  localparam int HW   = (Dlitl > 1) ? $clog2(Dlitl) : 1;
  localparam int PMAX = (Tcs > Dlitl) ? Tcs : Dlitl;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(Dlitl - 1);
  localparam logic [PW-1:0] P_LAST = PW'(Tcs - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, ADR, GAP, DAT, CS_HOLD, RECOVER} state_t;

  state_t        state;
  logic [SW-1:0] sh;
  logic [HW-1:0] hcnt;
  logic [PW-1:0] pcnt;
  logic [5:0]    bcnt;
  logic          ph;
  logic          rd_q;
  logic          rd_sel;
  logic [5:0]    field_bits;
  logic          accept;
  logic          half_end;
  logic          bit_rise;
  logic          field_end;

  assign accept     = req_valid && req_ready;
  assign field_bits = (state == ADR) ? 6'd8 : 6'(Nbit);
  assign half_end   = (hcnt == H_LAST);
  // A field is 2*bits+1 half periods: low/high per bit, then one trailing low half.
  assign bit_rise   = half_end && !ph && (bcnt != field_bits);
  assign field_end  = half_end && !ph && (bcnt == field_bits);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sh        <= '0;
      hcnt      <= '0;
      pcnt      <= '0;
      bcnt      <= '0;
      ph        <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      cs        <= 1'b1;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= CS_SETUP;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cs        <= 1'b0;
            pcnt      <= '0;
            sh        <= {~rd_sel, req_adr, req_data};
          end
        end
        CS_SETUP: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == P_LAST) begin
            state <= ADR;
            mosi  <= sh[SW-1];
            hcnt  <= '0;
            bcnt  <= '0;
            ph    <= 1'b0;
          end
        end
        ADR, DAT: begin
          hcnt <= half_end ? '0 : hcnt + 1'b1;
          if (field_end) begin
            state <= (state == ADR) ? GAP : CS_HOLD;
            mosi  <= 1'b1;
            pcnt  <= '0;
          end else if (bit_rise) begin
            ph   <= 1'b1;
            sclk <= 1'b1;
          end else if (half_end && ph) begin
            ph   <= 1'b0;
            sclk <= 1'b0;
            bcnt <= bcnt + 6'd1;
            // The last bit stays on mosi through the trailing half period.
            if (bcnt + 6'd1 != field_bits) begin
              sh   <= sh << 1;
              mosi <= (state == DAT && rd_q) || sh[SW-2];
            end
          end
        end
        GAP: begin
          state <= DAT;
          sh    <= sh << 1;
          mosi  <= rd_q || sh[SW-2];
          hcnt  <= '0;
          bcnt  <= '0;
          ph    <= 1'b0;
        end
        CS_HOLD: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == P_LAST) begin
            state <= RECOVER;
            cs    <= 1'b1;
            done  <= 1'b1;
            pcnt  <= '0;
          end
        end
        RECOVER: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == P_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MST_READ_EN
  logic [Nbit-1:0] rd_shift;

  assign rd_sel = req_rd;

  // miso is taken on the clk edge that raises sclk, when the slave's bit is settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q     <= 1'b0;
      rd_shift <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) rd_q <= req_rd;
      if (state == DAT && bit_rise) rd_shift <= (rd_shift << 1) | Nbit'(miso);
      if (state == CS_HOLD && pcnt == P_LAST && rd_q) begin
        rd_data  <= rd_shift;
        rd_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_in;

  assign rd_sel    = 1'b0;
  assign rd_q      = 1'b0;
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
  assign unused_in = req_rd ^ miso;
`endif

endmodule

// File: tb/tb_spi_master_write.sv
// tb/tb_spi_master_write.sv - randomized frames on two configurations checked against a timing-rule model
module tb_spi_master_write;
`ifdef SPI_MST_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_rd = 1'b0, a_miso = 1'b1;
  logic [6:0]  a_adr = '0;
  logic [31:0] a_data = '0;
  logic        a_ready, a_sclk, a_mosi, a_cs, a_busy, a_done, a_rd_valid;
  logic [31:0] a_rd_data;

  logic        b_valid = 1'b0, b_rd = 1'b0, b_miso = 1'b1;
  logic [6:0]  b_adr = '0;
  logic [7:0]  b_data = '0;
  logic        b_ready, b_sclk, b_mosi, b_cs, b_busy, b_done, b_rd_valid;
  logic [7:0]  b_rd_data;

  spi_master_write dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_adr(a_adr),
    .req_data(a_data), .req_rd(a_rd), .sclk(a_sclk), .mosi(a_mosi), .cs(a_cs), .miso(a_miso),
    .busy(a_busy), .done(a_done), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  spi_master_write #(.Nbit(8), .Dlitl(1), .Tcs(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_adr(b_adr),
    .req_data(b_data), .req_rd(b_rd), .sclk(b_sclk), .mosi(b_mosi), .cs(b_cs), .miso(b_miso),
    .busy(b_busy), .done(b_done), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  int          tests = 0;
  int          fails = 0;
  int          a_hi_run = 0;
  int          a_last_hi = 0;
  int          last_wait = 0;
  logic [31:0] last_rd [2];

  // Length of the most recent complete cs-high run on instance A.
  always @(negedge clk) begin
    if (a_cs) a_hi_run++;
    else begin
      if (a_hi_run != 0) a_last_hi = a_hi_run;
      a_hi_run = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {sclk, mosi} at offset o into a field of n bits sent MSB first.
  function automatic logic [1:0] field_pin(int o, int n, int d, logic [31:0] v);
    int i;
    i = o / (2 * d);
    if (i >= n) return {1'b0, v[0]};
    return {(o % (2 * d)) >= d, v[n-1-i]};
  endfunction

  // {cs, sclk, mosi} for cycle c, where c=1 is the cycle after the accept edge.
  function automatic logic [2:0] model_pins(int c, int n, int d, int t, logic [7:0] af,
                                            logic [31:0] dv, bit rd);
    int a0, g, d0, dend, len;
    logic [1:0] fp;
    len  = 2 * t + 17 * d + 1 + (2 * n + 1) * d;
    a0   = t + 1;
    g    = a0 + 17 * d;
    d0   = g + 1;
    dend = d0 + (2 * n + 1) * d;
    if (c < 1 || c > len) return 3'b101;
    if (c < a0 || c == g || c >= dend) return 3'b001;
    if (c < g) begin
      fp = field_pin(c - a0, 8, d, {24'b0, af});
      return {1'b0, fp};
    end
    fp = field_pin(c - d0, n, d, dv);
    return rd ? {1'b0, fp[1], 1'b1} : {1'b0, fp};
  endfunction

  task automatic drive(input bit sel, input bit v, input logic [6:0] adr, input logic [31:0] data,
                       input bit rd);
    if (sel) begin
      b_valid = v; b_adr = adr; b_data = data[7:0]; b_rd = rd;
    end else begin
      a_valid = v; a_adr = adr; a_data = data; a_rd = rd;
    end
  endtask

  function automatic logic [6:0] pins(bit sel);
    if (sel) return {b_cs, b_sclk, b_mosi, b_ready, b_busy, b_done, b_rd_valid};
    return {a_cs, a_sclk, a_mosi, a_ready, a_busy, a_done, a_rd_valid};
  endfunction

  // Entered and left just after a falling clk edge.
  task automatic frame(input bit sel, input logic [6:0] adr, input logic [31:0] data, input bit rd,
                       input bit hold, input int abort_c, input logic [31:0] miso_word,
                       input string tag);
    int n, d, t, len, waitc, wm, hm, cslow, rises, first_bad, od, done_seen;
    logic [63:0] shreg;
    logic [6:0]  o;
    logic [31:0] rdd, mask, dv, exp_rdd;
    logic [7:0]  af;
    bit rde, prev_sclk, m;
    n = sel ? 8 : 32;
    d = sel ? 1 : 5;
    t = sel ? 1 : 10;
    len  = 2 * t + 17 * d + 1 + (2 * n + 1) * d;
    mask = (n == 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
    rde  = READ_EN && rd;
    af   = {~rde, adr};
    dv   = data & mask;
    drive(sel, 1'b1, adr, data, rd);
    waitc = 0;
    while (!(sel ? b_ready : a_ready) && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, "/accept_in_time"}, 64'(waitc < 1000), 64'd1);
    if (waitc >= 1000) begin
      drive(sel, 1'b0, adr, data, rd);
      return;
    end
    last_wait = waitc;
    wm = 0; hm = 0; cslow = 0; rises = 0; first_bad = -1;
    shreg = '0; prev_sclk = 1'b0; rdd = '0;
    for (int c = 1; c <= len + t + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) drive(sel, 1'b0, 7'($urandom), $urandom, 1'($urandom));
      o = pins(sel);
      if (o[6:4] !== model_pins(c, n, d, t, af, dv, rde)) begin
        wm++;
        if (first_bad < 0) first_bad = c;
      end
      if (o[3:0] !== {c > len + t, c <= len + t, c == len + 1, rde && c == len + 1}) hm++;
      if (!o[6]) cslow++;
      if (o[5] && !prev_sclk) begin
        rises++;
        shreg = {shreg[62:0], o[4]};
      end
      prev_sclk = o[5];
      if (o[1]) rdd = sel ? {24'b0, b_rd_data} : a_rd_data;
      od = c - (t + 2 + 17 * d);
      m  = (od >= 0 && od < 2 * n * d) ? miso_word[n-1-od/(2*d)] : 1'b1;
      if (sel) b_miso = m; else a_miso = m;
      if (c == abort_c) begin
        chk($sformatf("%s/wave_before_reset(first bad cycle %0d)", tag, first_bad), 64'(wm), 64'd0);
        rst = 1'b0;
        #1;
        o = pins(sel);
        chk({tag, "/reset_pins"}, 64'(o[6:4]), 64'(3'b101));
        chk({tag, "/reset_ready_busy"}, 64'(o[3:2]), 64'd0);
        done_seen = 0;
        repeat (3) begin
          @(negedge clk);
          if (a_done || b_done) done_seen++;
        end
        rst = 1'b1;
        repeat (2) begin
          @(negedge clk);
          if (a_done || b_done) done_seen++;
        end
        chk({tag, "/no_done_after_reset"}, 64'(done_seen), 64'd0);
        chk({tag, "/rd_data_reset"}, 64'(sel ? {24'b0, b_rd_data} : a_rd_data), 64'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        return;
      end
    end
    exp_rdd = rde ? (miso_word & mask) : last_rd[sel];
    last_rd[sel] = exp_rdd;
    chk($sformatf("%s/wave(first bad cycle %0d)", tag, first_bad), 64'(wm), 64'd0);
    chk({tag, "/ready_busy_done"}, 64'(hm), 64'd0);
    chk({tag, "/cs_low_cycles"}, 64'(cslow), 64'(len));
    chk({tag, "/sclk_pulses"}, 64'(rises), 64'(8 + n));
    chk({tag, "/slave_adr"}, 64'(shreg[n +: 8]), 64'(af));
    chk({tag, "/slave_data"}, shreg & {32'b0, mask}, 64'(rde ? mask : dv));
    chk({tag, "/rd_data"}, 64'(rdd), 64'(exp_rdd));
  endtask

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", 64'({a_cs, a_sclk, a_mosi, a_ready, a_busy, a_done, a_rd_valid}),
        64'(7'b1010000));
    chk("reset_a_rd_data", 64'(a_rd_data), 64'd0);
    chk("reset_b", 64'({b_cs, b_sclk, b_mosi, b_ready, b_busy, b_done, b_rd_valid}),
        64'(7'b1010000));
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'({a_ready, b_ready}), 64'(2'b11));

    frame(1'b0, 7'h01, 32'hDEEDBEEF, 1'b0, 1'b0, 0, 32'h0, "a_deedbeef");
    frame(1'b0, 7'h05, 32'h1234_5678, 1'b1, 1'b0, 0, 32'hA5A5_0F0F, "a_read05");
    repeat (3) frame(1'b0, 7'($urandom), $urandom, 1'($urandom), 1'b0, 0, $urandom, "a_rand");

    frame(1'b0, 7'($urandom), $urandom, 1'b0, 1'b1, 0, 32'h0, "a_b2b_first");
    frame(1'b0, 7'($urandom), $urandom, 1'b0, 1'b0, 0, 32'h0, "a_b2b_second");
    chk("b2b_accept_wait", 64'(last_wait), 64'd0);
    chk("b2b_cs_high", 64'(a_last_hi), 64'd11);

    // Mid-high half of data bit index 11: 97 + 11*10 + 5.
    frame(1'b0, 7'($urandom), $urandom, 1'b0, 1'b0, 212, 32'h0, "a_abort");
    frame(1'b0, 7'h2A, 32'h8000_0001, 1'b0, 1'b0, 0, 32'h0, "a_after_reset");

    frame(1'b1, 7'h7F, 32'h0000_00FF, 1'b0, 1'b0, 0, 32'h0, "b_ones");
    frame(1'b1, 7'h00, 32'h0000_0000, 1'b0, 1'b0, 0, 32'h0, "b_zeros");
    frame(1'b1, 7'h05, 32'h0000_003C, 1'b1, 1'b0, 0, 32'h0000_00A5, "b_read");
    repeat (4) frame(1'b1, 7'($urandom), $urandom, 1'($urandom), 1'b0, 0, $urandom, "b_rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
